multi_function_register_seq: RTL
================================

Name: multi_function_register_seq

Overview:
- Parametrised successor to the team's 4-bit multi-function register.
- WIDTH-bit register with an opcode-driven operation set: load, increment/decrement with optional saturation, logical/arithmetic shift, rotate.
- Multi-bit shifts run on an iterative one-bit-per-cycle engine, so operations use a valid/ready handshake with busy and done status.
- Sits in the datapath as a general-purpose accumulator/shift register under control-FSM command.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- SAT, 0, 1 = INC/DEC saturate at all-ones/zero; 0 = INC/DEC wrap modulo 2^WIDTH.
- SHW, $clog2(WIDTH), width of the shift-amount field (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  command present.
- op_ready  output  1  block can accept a command; equals !busy.
- op  input  3  opcode: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 SHL, 5 SHR, 6 ASR, 7 ROL.
- din  input  WIDTH  LOAD data.
- shamt  input  SHW  shift/rotate amount for ops 4-7, range 0..WIDTH-1.
- q  output  WIDTH  register contents.
- carry  output  1  carry/borrow/last bit shifted out of the most recent completed op.
- zero  output  1  combinational (q == 0).
- busy  output  1  multi-cycle shift in progress.
- done  output  1  one-cycle pulse, registered, high in the cycle after an op completes.

Behaviour:
- Reset (async, any time, including mid-shift): q=0, carry=0, done=0, busy=0, FSM -> IDLE, shift counter=0; the in-flight op is discarded.
- Accept: a command is accepted at a rising edge when op_valid && op_ready. op, din and shamt are sampled only at accept. op_valid while busy is ignored; no queueing.
- FSM states: IDLE, SHIFT.
- IDLE, single-cycle ops:
  - NOP: q and carry unchanged; done still pulses.
  - LOAD: q=din, carry=0.
  - INC: q=q+1; carry=1 if q was all-ones. If SAT=1, q holds at all-ones and carry=1.
  - DEC: q=q-1; carry=1 (borrow) if q was 0. If SAT=1, q holds at 0 and carry=1.
  - Shift/rotate ops with shamt=0: q unchanged, carry=0.
  - All of the above update q and carry at the accept edge, stay in IDLE, and register done=1 at that edge.
- IDLE, shift/rotate ops with shamt=N>0: at the accept edge, latch the opcode, set counter=N, go to SHIFT, busy=1. q is not modified at the accept edge.
- SHIFT, one bit per edge:
  - SHL: q={q[WIDTH-2:0],0}, carry=q[WIDTH-1].
  - SHR: q={0,q[WIDTH-1:1]}, carry=q[0].
  - ASR: q={q[WIDTH-1],q[WIDTH-1:1]}, carry=q[0].
  - ROL: q={q[WIDTH-2:0],q[WIDTH-1]}, carry=q[WIDTH-1].
  - Counter decrements each edge. The edge that brings the counter 1->0 applies the final shift, returns to IDLE, clears busy and registers done=1.
- Latency: single-cycle op, done high 1 cycle after accept. Shift by N, q final and done high N+1 cycles after accept (N shift edges after the accept edge).
- done is never high for more than one cycle per op. A new command can be accepted in the same cycle done is high.
- carry holds its value between ops and reflects the last bit processed. Intermediate carry values during SHIFT are visible.
- op_ready is combinational from busy only; it must not depend on op_valid.

Test Plan:
- Reset then LOAD din=0xA5 -> q=0xA5, carry=0, zero=0, done pulse 1 cycle after accept; async reset asserted mid-cycle -> q=0 immediately, zero=1.
- SAT=0: LOAD 0xFF, INC -> q=0x00, carry=1, zero=1; DEC -> q=0xFF, carry=1. SAT=1: LOAD 0xFF, INC -> q=0xFF, carry=1; LOAD 0, DEC -> q=0x00, carry=1.
- LOAD 0x81, SHL shamt=3 -> busy 3 cycles, op_ready=0, q sequence 0x02,0x04,0x08, carry final 0, done on 4th cycle after accept; op_valid with LOAD during busy ignored.
- LOAD 0x90, ASR shamt=4 -> q=0xF9, carry=0; LOAD 0x90, SHR shamt=4 -> q=0x09; LOAD 0x81, ROL shamt=1 -> q=0x03, carry=1.
- SHL shamt=0 on q=0x55 -> q=0x55, carry=0, done 1 cycle later, busy never asserted.
- LOAD 0xFF, SHR shamt=7, reset asserted after 2 shift edges -> q=0, busy=0, op_ready=1, no done pulse; next LOAD 0x12 is accepted normally.

Source files
------------

// File: rtl/multi_function_register_seq.sv
// ============================================================================
// Module   : multi_function_register_seq
// Purpose  : WIDTH-bit accumulator/shift register with an opcode command set and
//            an iterative shifter that moves one bit per cycle.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module multi_function_register_seq #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;

  localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   C_CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0]   C_CNT_ZERO = {SHW{1'b0}};

  logic [0:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shift_val_w;
  logic             shift_carry_w;

  // Single-bit step of the latched shift/rotate opcode.
  always_comb begin
    shift_val_w   = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
    shift_carry_w = reg_q[WIDTH-1];
    case (op_q)
      OP_SHL: begin
        shift_val_w   = {reg_q[WIDTH-2:0], 1'b0};
        shift_carry_w = reg_q[WIDTH-1];
      end
      OP_SHR: begin
        shift_val_w   = {1'b0, reg_q[WIDTH-1:1]};
        shift_carry_w = reg_q[0];
      end
      OP_ASR: begin
        shift_val_w   = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
        shift_carry_w = reg_q[0];
      end
      default: begin
        shift_val_w   = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        shift_carry_w = reg_q[WIDTH-1];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          done_d = 1'b1;
          case (op)
            OP_NOP: begin
            end
            OP_LOAD: begin
              reg_d   = din;
              carry_d = 1'b0;
            end
            OP_INC: begin
              if (reg_q == C_ALL_ONES) begin
                carry_d = 1'b1;
                reg_d   = (SAT != 0) ? C_ALL_ONES : C_ZERO;
              end else begin
                carry_d = 1'b0;
                reg_d   = reg_q + C_ONE;
              end
            end
            OP_DEC: begin
              if (reg_q == C_ZERO) begin
                carry_d = 1'b1;
                reg_d   = (SAT != 0) ? C_ZERO : C_ALL_ONES;
              end else begin
                carry_d = 1'b0;
                reg_d   = reg_q - C_ONE;
              end
            end
            default: begin
              // Zero-length shifts finish immediately; others hand off to SHIFT.
              if (shamt == C_CNT_ZERO) begin
                carry_d = 1'b0;
              end else begin
                done_d  = 1'b0;
                op_d    = op;
                cnt_d   = shamt;
                state_d = S_SHIFT;
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        reg_d   = shift_val_w;
        carry_d = shift_carry_w;
        cnt_d   = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= C_CNT_ZERO;
      reg_q   <= C_ZERO;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign op_ready = ~busy;
  assign q        = reg_q;
  assign carry    = carry_q;
  assign zero     = (reg_q == C_ZERO);
  assign done     = done_q;

endmodule

`default_nettype wire
